count_seq_ctrl: RTL
===================

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 The block SHALL have parameter `WIDTH`, default 4, which sets the counter data width.
REQ-002 The block SHALL have port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `start`, input, 1 bit: request to run one programmed sequence.
REQ-005 The block SHALL have port `abort`, input, 1 bit: terminate the running sequence.
REQ-006 The block SHALL have ports `cfg_lo`, `cfg_hi` and `cfg_reps`, each input, WIDTH bits: floor, ceiling and repetition count, captured when start is accepted.
REQ-007 The block SHALL have port `count`, input, WIDTH bits: feedback from the up/down counter output.
REQ-008 The block SHALL have port `din`, output, WIDTH bits: load value driven to the counter.
REQ-009 The block SHALL have ports `load`, `up_down` and `ctr_reset`, each output, 1 bit: counter controls (up_down=1 counts up; ctr_reset is active-high).
REQ-010 The block SHALL have port `busy`, output, 1 bit: sequence in progress.
REQ-011 The block SHALL have ports `done`, `cfg_err` and `err`, each output, 1 bit: completion pulse, rejected-config pulse, and sticky mismatch flag.

Function
REQ-012 Outputs are registered; controls driven during cycle k are sampled by the counter at edge k+1.
REQ-013 FSM states: IDLE, CLR, LOAD, UP, DOWN, DONE, ERR.
REQ-014 IDLE: load=0, up_down=0, ctr_reset=0, din=0, busy=0; count is not checked.
REQ-015 start in IDLE with cfg_lo<cfg_hi and cfg_reps!=0: capture config; next state CLR.
REQ-016 start in IDLE with cfg_lo>=cfg_hi or cfg_reps==0: cfg_err=1 for one cycle; stay IDLE; config not captured.
REQ-017 start outside IDLE and ERR is ignored.
REQ-018 CLR (1 cycle): ctr_reset=1, busy=1; next state LOAD.
REQ-019 LOAD (1 cycle): load=1, din=lo, busy=1; internal shadow becomes lo; next state UP.
REQ-020 UP: up_down=1, load=0, busy=1; shadow increments each cycle.
REQ-021 UP exits to DOWN on the edge where shadow becomes hi.
REQ-022 DOWN: up_down=0, busy=1; shadow decrements each cycle.
REQ-023 DOWN exits on the edge where shadow becomes lo, and the remaining-reps counter decrements on that edge.
REQ-024 On DOWN exit, next state is UP if the remaining reps are still nonzero, else DONE.
REQ-025 DONE (1 cycle): done=1, busy=0; next state IDLE.
REQ-026 Latency: done SHALL assert exactly 3+2*(hi-lo)*reps cycles after the cycle in which start was sampled.
REQ-027 In every cycle of UP, DOWN and DONE, if count != shadow then err=1 (sticky) and next state is ERR.
REQ-028 ERR: ctr_reset=1, busy=0, err=1; exit only via start.
REQ-029 start in ERR clears err; it then follows the IDLE acceptance rules of REQ-015 and REQ-016 in the same cycle.
REQ-030 abort in CLR, LOAD, UP, DOWN or DONE: next state IDLE, with ctr_reset=1 for that one cycle; done is not asserted.
REQ-031 start and abort in the same cycle: abort wins; start is dropped.
REQ-032 Shadow arithmetic is WIDTH bits; wrap-around cannot occur because lo<hi is enforced by REQ-015/REQ-016.

Reset
REQ-033 While reset=0, asynchronously: state=IDLE; din=0, load=0, up_down=0, ctr_reset=0, busy=0, done=0, cfg_err=0, err=0; config and shadow cleared.
REQ-034 Reset asserted mid-sequence SHALL discard the sequence, with no done pulse after release.
REQ-035 The first state transition SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-036 lo=2, hi=5, reps=1, with a compliant counter -> count 2,3,4,5,4,3 over UP/DOWN; done pulses at cycle 9; err=0.
REQ-037 lo=0, hi=15, reps=2 -> count reaches 15 twice and 0 three times; done at cycle 63; busy low in the done cycle.
REQ-038 lo=7, hi=7 (also reps=0) -> cfg_err 1-cycle pulse; busy stays 0; no counter controls toggle.
REQ-039 Counter forced to a wrong count mid-UP -> err=1 in that cycle; ERR holds ctr_reset=1; a later valid start clears err and runs normally.
REQ-040 abort asserted in DOWN (also abort together with start) -> IDLE next cycle with a one-cycle ctr_reset; no done; start dropped.
REQ-041 reset pulled low mid-UP -> all outputs 0 immediately; after release a new start runs the full, correct sequence.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - sequencer driving an external up/down counter between a floor and a ceiling
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [WIDTH-1:0] cfg_reps,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] din,
    output logic             load,
    output logic             up_down,
    output logic             ctr_reset,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, CLR, LOAD, UP, DOWN, DONE, ERR} state_t;

    state_t           state;
    logic [WIDTH-1:0] lo, hi, reps, shadow;
    logic [WIDTH-1:0] shadow_inc, shadow_dec, reps_dec;
    logic             cfg_ok, start_ok, mismatch;

    assign shadow_inc = shadow + WIDTH'(1);
    assign shadow_dec = shadow - WIDTH'(1);
    assign reps_dec   = reps - WIDTH'(1);
    assign cfg_ok     = (cfg_lo < cfg_hi) && (cfg_reps != '0);
    assign start_ok   = start && !abort;
    assign mismatch   = (count != shadow);

    // Shadow tracks the value the counter must hold in the current cycle;
    // the counter lags the registered controls by one edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lo        <= '0;
            hi        <= '0;
            reps      <= '0;
            shadow    <= '0;
            din       <= '0;
            load      <= 1'b0;
            up_down   <= 1'b0;
            ctr_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            err       <= 1'b0;
        end else begin
            din       <= '0;
            load      <= 1'b0;
            up_down   <= 1'b0;
            ctr_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start_ok) begin
                        err <= 1'b0;
                        if (cfg_ok) begin
                            lo        <= cfg_lo;
                            hi        <= cfg_hi;
                            reps      <= cfg_reps;
                            state     <= CLR;
                            ctr_reset <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (state == ERR) begin
                        ctr_reset <= 1'b1;
                    end
                end
                CLR: begin
                    if (abort) begin
                        state     <= IDLE;
                        ctr_reset <= 1'b1;
                    end else begin
                        state <= LOAD;
                        load  <= 1'b1;
                        din   <= lo;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        ctr_reset <= 1'b1;
                    end else begin
                        shadow  <= lo;
                        state   <= UP;
                        up_down <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                UP: begin
                    if (abort) begin
                        state     <= IDLE;
                        ctr_reset <= 1'b1;
                    end else if (mismatch) begin
                        state     <= ERR;
                        err       <= 1'b1;
                        ctr_reset <= 1'b1;
                    end else begin
                        shadow <= shadow_inc;
                        busy   <= 1'b1;
                        if (shadow_inc == hi) begin
                            state <= DOWN;
                        end else begin
                            up_down <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state     <= IDLE;
                        ctr_reset <= 1'b1;
                    end else if (mismatch) begin
                        state     <= ERR;
                        err       <= 1'b1;
                        ctr_reset <= 1'b1;
                    end else begin
                        shadow <= shadow_dec;
                        busy   <= 1'b1;
                        if (shadow_dec == lo) begin
                            reps <= reps_dec;
                            if (reps_dec != '0) begin
                                state   <= UP;
                                up_down <= 1'b1;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state     <= IDLE;
                        ctr_reset <= 1'b1;
                    end else if (mismatch) begin
                        state     <= ERR;
                        err       <= 1'b1;
                        ctr_reset <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
